// File: rtl/stream_mux_n_to_1.sv
// Registered N:1 stream multiplexer; the grant is held until a beat with last is accepted.
// Define STREAM_MUX_ROUND_ROBIN_EN to replace fixed sel with round-robin arbitration.
module stream_mux_n_to_1 #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [SEL_W-1:0]         cur_ch
);

  localparam int PAD_W = 2**SEL_W;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [SEL_W-1:0]    cur_ch_r;
  logic [SEL_W-1:0]    cand_s;
  logic                cand_ok_s;
  logic                accept_s;
  logic                slot_free_s;
  logic [PAD_W-1:0]    valid_pad_s;
  logic [PAD_W-1:0]    last_pad_s;
  logic [DATA_W-1:0]   ch_data_s [NUM_CH];
  logic [DATA_W-1:0]   out_data_r;
  logic                out_valid_r;
  logic                out_last_r;

  // Zero padding makes out-of-range sel values read as "not valid".
  assign valid_pad_s = PAD_W'(in_valid);
  assign last_pad_s  = PAD_W'(in_last);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_split
    assign ch_data_s[c] = in_data[c*DATA_W +: DATA_W];
  end

`ifdef STREAM_MUX_ROUND_ROBIN_EN
  logic unused_sel_s;
  assign unused_sel_s = ^sel;

  // Round-robin candidate: first valid channel after the last grant.
  always_comb begin
    logic [SEL_W-1:0] rr_idx;
    logic             hit;
    cand_s    = cur_ch_r;
    cand_ok_s = 1'b0;
    rr_idx    = cur_ch_r;
    hit       = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      rr_idx    = SEL_W'((int'(cur_ch_r) + k) % NUM_CH);
      hit       = valid_pad_s[rr_idx] && !cand_ok_s;
      cand_s    = hit ? rr_idx : cand_s;
      cand_ok_s = cand_ok_s || hit;
    end
  end
`else
  // Fixed-select candidate.
  always_comb begin
    cand_s    = sel;
    cand_ok_s = valid_pad_s[sel];
  end
`endif

  // Next-state, per-channel ready and accept decode.
  always_comb begin
    state_nxt_s = state_r;
    in_ready    = '0;
    accept_s    = 1'b0;
    slot_free_s = !out_valid_r || out_ready;
    case (state_r)
      IDLE: begin
        if (cand_ok_s) begin
          state_nxt_s = LOCKED;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOCKED: begin
        in_ready[cur_ch_r] = slot_free_s;
        accept_s           = valid_pad_s[cur_ch_r] && slot_free_s;
        if (accept_s && last_pad_s[cur_ch_r]) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and grant register; cur_ch reset makes the round-robin search start at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cur_ch_r <= SEL_W'(NUM_CH - 1);
    end else begin
      state_r <= state_nxt_s;
      if (state_r == IDLE && cand_ok_s) begin
        cur_ch_r <= cand_s;
      end
    end
  end

  // Output register: load on accept, drain on downstream accept, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (accept_s) begin
      out_data_r  <= ch_data_s[cur_ch_r];
      out_last_r  <= last_pad_s[cur_ch_r];
      out_valid_r <= 1'b1;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = (state_r == LOCKED);
  assign cur_ch    = cur_ch_r;

endmodule
